// File: rtl/rll_key_loader.sv
// Serial key loader for the RLL16-locked cores: shifts in key + checksum over valid/ready,
// verifies the chunked-XOR checksum, commits the key and locks out after repeated failures.
module rll_key_loader #(
  parameter int KEY_W        = 16,
  parameter int CHK_W        = 4,
  parameter int MAX_ATTEMPTS = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_start,
  input  logic             key_bit,
  input  logic             key_bit_valid,
  output logic             key_bit_ready,
  input  logic             key_clear,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             load_err,
  output logic             locked_out,
  output logic [3:0]       fail_cnt
);
  localparam int SR_W  = KEY_W + CHK_W;
  localparam int CNT_W = $clog2(SR_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SR_W - 1);
  localparam logic [3:0] MAX_F = 4'(MAX_ATTEMPTS);

  typedef enum logic [2:0] {IDLE, SHIFT, CHECK, LOADED, ERROR} state_t;

  state_t           state;
  logic [SR_W-1:0]  sreg;
  logic [CNT_W-1:0] cnt;
  logic [CHK_W-1:0] chk_exp;
  logic             chk_ok;
  logic [3:0]       fail_nxt;

  // Expected checksum: XOR of all CHK_W-wide chunks of the received key.
  always_comb begin
    chk_exp = '0;
    for (int i = 0; i < KEY_W / CHK_W; i++)
      chk_exp = chk_exp ^ sreg[CHK_W + i*CHK_W +: CHK_W];
  end

  assign chk_ok   = (chk_exp == sreg[CHK_W-1:0]);
  assign fail_nxt = fail_cnt + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      key_out       <= '0;
      key_valid     <= 1'b0;
      key_bit_ready <= 1'b0;
      load_err      <= 1'b0;
      locked_out    <= 1'b0;
      fail_cnt      <= '0;
      cnt           <= '0;
      sreg          <= '0;
    end else begin
      load_err <= 1'b0;
      case (state)
        IDLE: begin
          if (load_start) begin
            state         <= SHIFT;
            cnt           <= '0;
            key_bit_ready <= 1'b1;
          end
        end
        SHIFT: begin
          // A restart discards whatever bit is presented alongside it.
          if (load_start) begin
            cnt <= '0;
          end else if (key_bit_valid && key_bit_ready) begin
            sreg <= {sreg[SR_W-2:0], key_bit};
            cnt  <= cnt + 1'b1;
            if (cnt == LAST) begin
              state         <= CHECK;
              key_bit_ready <= 1'b0;
            end
          end
        end
        CHECK: begin
          if (chk_ok) begin
            key_out   <= sreg[SR_W-1:CHK_W];
            key_valid <= 1'b1;
            fail_cnt  <= '0;
            state     <= LOADED;
          end else begin
            load_err <= 1'b1;
            fail_cnt <= fail_nxt;
            if (fail_nxt == MAX_F) begin
              state      <= ERROR;
              locked_out <= 1'b1;
              key_out    <= '0;
              key_valid  <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
        end
        LOADED: begin
          // Clear has priority; load_start is never honoured here.
          if (key_clear) begin
            key_out   <= '0;
            key_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        ERROR: begin
          locked_out    <= 1'b1;
          key_out       <= '0;
          key_valid     <= 1'b0;
          key_bit_ready <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rll_key_loader.sv
// Scoreboard bench for rll_key_loader: load outcomes are predicted when the last bit
// is driven and checked when key_valid rises or load_err pulses.
module tb_rll_key_loader;
  logic        clk = 1'b0;
  logic        rst_n, load_start, key_bit, key_bit_valid, key_clear;
  logic        key_bit_ready, key_valid, load_err, locked_out;
  logic [15:0] key_out;
  logic [3:0]  fail_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    bit          err;
    logic [15:0] key;
    logic [3:0]  fail;
    int          cyc;
  } ev_t;
  ev_t q[$];

  logic [15:0] m_key  = '0;
  logic [3:0]  m_fail = '0;

  rll_key_loader dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .key_bit(key_bit),
    .key_bit_valid(key_bit_valid), .key_bit_ready(key_bit_ready), .key_clear(key_clear),
    .key_out(key_out), .key_valid(key_valid), .load_err(load_err),
    .locked_out(locked_out), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_key"},   key_out, 0);
    chk({tag, "_kv"},    key_valid, 0);
    chk({tag, "_rdy"},   key_bit_ready, 0);
    chk({tag, "_err"},   load_err, 0);
    chk({tag, "_lock"},  locked_out, 0);
    chk({tag, "_fail"},  fail_cnt, 0);
  endtask

  // Monitor: every load outcome must match the next scoreboard entry.
  bit kv_d = 0, err_d = 0;
  always @(negedge clk) begin
    ev_t e;
    if (rst_n) begin
      if (load_err && err_d) chk("err_pulse_len", 1, 0);
      if (load_err || (key_valid && !kv_d)) begin
        if (q.size() == 0) chk("unexpected_event", 1, 0);
        else begin
          e = q.pop_front();
          chk("ev_kind", load_err, e.err);
          chk("ev_key",  key_out, e.key);
          chk("ev_fail", fail_cnt, e.fail);
          chk("ev_lat",  cyc, e.cyc + 1);
        end
      end
    end
    kv_d  = key_valid;
    err_d = load_err;
  end

  function automatic logic [3:0] xsum(input logic [15:0] k);
    return k[15:12] ^ k[11:8] ^ k[7:4] ^ k[3:0];
  endfunction

  // Called at posedge+1; returns at posedge+1.
  task automatic stream(input logic [15:0] k, input logic [3:0] c, input bit tog,
                        input int restart_at, output int rdy_cyc);
    logic [19:0] s;
    int i, n;
    bit rs, v, acc, rst_req;
    ev_t e;
    s = {k, c}; i = 0; n = 0; rs = 0; rdy_cyc = 0;
    load_start = 1'b1;
    @(posedge clk); #1 load_start = 1'b0;
    while (i < 20 && n < 200) begin
      v = !tog || (n % 2 == 0);
      key_bit = s[19-i];
      key_bit_valid = v;
      if (!rs && restart_at >= 0 && i == restart_at) begin
        load_start = 1'b1;
        rs = 1;
      end
      @(negedge clk);
      if (key_bit_ready) rdy_cyc++;
      acc = v && key_bit_ready && !load_start;
      rst_req = load_start;
      @(posedge clk); #1;
      if (rst_req) begin
        i = 0;
        load_start = 1'b0;
      end else if (acc) begin
        i++;
        if (i == 20) begin
          if (xsum(k) == c) begin
            m_fail = '0; m_key = k;
            e = '{err: 1'b0, key: k, fail: 4'd0, cyc: cyc};
          end else begin
            m_fail = m_fail + 4'd1;
            e = '{err: 1'b1, key: m_key, fail: m_fail, cyc: cyc};
          end
          q.push_back(e);
        end
      end
      n++;
    end
    key_bit_valid = 1'b0;
    if (i < 20) chk("stream_timeout", i, 20);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    #1 chk_reset_vals("async_rst");
    m_fail = '0; m_key = '0;
    q.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic clear_key();
    key_clear = 1'b1;
    @(posedge clk); #1 key_clear = 1'b0;
    m_key = '0;
  endtask

  initial begin
    int rc, ready_seen;
    rst_n = 1'b0; load_start = 0; key_bit = 0; key_bit_valid = 0; key_clear = 0;
    #1 chk_reset_vals("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: clean load
    stream(16'hA5C3, 4'h0, 0, -1, rc);
    chk("t1_rdy_cycles", rc, 20);
    @(negedge clk) chk("t1_rdy_low_check", key_bit_ready, 0);
    @(posedge clk); #1;
    drain();
    chk("t1_key", key_out, 16'hA5C3);
    chk("t1_kv", key_valid, 1);
    clear_key();
    chk("t1_clear_key", key_out, 0);

    // 2: bad checksum then good
    stream(16'h1234, 4'h5, 0, -1, rc);
    drain();
    chk("t2_fail", fail_cnt, 1);
    chk("t2_key_kept", key_out, 0);
    chk("t2_idle_rdy", key_bit_ready, 0);
    stream(16'h1234, 4'h4, 0, -1, rc);
    drain();
    chk("t2_key", key_out, 16'h1234);
    chk("t2_fail0", fail_cnt, 0);
    clear_key();

    // 3: lockout
    for (int k = 0; k < 3; k++) begin
      stream(16'h1234, 4'h0, 0, -1, rc);
      drain();
    end
    chk("t3_fail", fail_cnt, 3);
    chk("t3_lock", locked_out, 1);
    load_start = 1'b1; key_bit_valid = 1'b1;
    @(posedge clk); #1 load_start = 1'b0;
    ready_seen = 0;
    for (int k = 0; k < 25; k++) begin
      key_bit = k[0];
      @(negedge clk); if (key_bit_ready) ready_seen++;
      @(posedge clk); #1;
    end
    key_bit_valid = 1'b0;
    chk("t3_no_ready", ready_seen, 0);
    chk("t3_key0", key_out, 0);
    chk("t3_kv0", key_valid, 0);
    chk("t3_still_lock", locked_out, 1);
    do_reset();
    chk("t3_unlock", locked_out, 0);

    // 4: toggling valid with mid-stream restart
    stream(16'h1234, 4'h4, 1, 7, rc);
    drain();
    chk("t4_key", key_out, 16'h1234);
    clear_key();

    // 5: clear and load_start together in LOADED
    stream(16'hA5C3, 4'h0, 0, -1, rc);
    drain();
    chk("t5_loaded", key_out, 16'hA5C3);
    key_clear = 1'b1; load_start = 1'b1;
    @(posedge clk); #1 key_clear = 1'b0; load_start = 1'b0;
    chk("t5_key", key_out, 0);
    chk("t5_kv", key_valid, 0);
    @(negedge clk) chk("t5_no_shift", key_bit_ready, 0);
    @(posedge clk); #1;
    m_key = '0;

    // 6: async reset in LOADED and mid-SHIFT
    stream(16'hA5C3, 4'h0, 0, -1, rc);
    drain();
    chk("t6_loaded", key_valid, 1);
    do_reset();
    load_start = 1'b1;
    @(posedge clk); #1 load_start = 1'b0; key_bit_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      key_bit = k[0];
      @(posedge clk); #1;
    end
    chk("t6_in_shift", key_bit_ready, 1);
    do_reset();
    key_bit_valid = 1'b0;
    chk("t6_post_idle", key_bit_ready, 0);
    chk("t6_q_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d want 0", 1);
    $fatal(1);
  end
endmodule
